ls_tile_burst: RTL and testbench
================================

// Module: ls_tile_burst
// PURPOSE
// Parametrised load/store tile at the PE-array edge, between one PE port and a 2-D (x,y) word memory.
// - Accepts single or burst load/store commands.
// - Issues in-order memory requests with a req/gnt handshake.
// - Buffers load returns in a credit-protected FIFO toward the PE.
// - Adds burst length, address wrap, back-pressure and outstanding-load tracking.
// PARAMETERS
// DATA_W      32  data word width
// AX_W        6   x address width (rows = 2**AX_W)
// AY_W        6   y address width (cols = 2**AY_W)
// LEN_W       4   burst length field width; beats = len+1 (1..2**LEN_W)
// FIFO_DEPTH  4   load-return FIFO depth (power of 2, >=2)
// PORTS
// clk            in   1                   clock, rising edge
// reset          in   1                   synchronous, active-high
// en             in   1                   tile enable; low freezes command accept and new issue
// ctrl           in   AX_W+AY_W+LEN_W+1   {x, y, len, we}; we=1 store, we=0 load
// input_ready    in   1                   PE side valid: command in IDLE, store data in ST
// FromPE         in   DATA_W              store data
// cmd_ready      out  1                   tile accepts command (IDLE) or store beat (ST)
// ToPE           out  DATA_W              load data = FIFO head
// output_ready   out  1                   ToPE valid (FIFO not empty)
// pe_ready       in   1                   PE consumes ToPE when output_ready && pe_ready
// mem_req        out  1                   memory request valid
// mem_we         out  1                   1 write, 0 read
// mem_x          out  AX_W                request row
// mem_y          out  AY_W                request column
// ToMemoryReg    out  DATA_W              write data, valid with mem_req && mem_we
// mem_gnt        in   1                   request accepted this cycle
// FromMemoryReg  in   DATA_W              read data, valid with mem_rvalid
// mem_rvalid     in   1                   read return, in request order, >=1 cycle after gnt
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, FIFO empty, outstanding=0, beat counters 0.
// - FSM IDLE/LD/ST.
//   - IDLE: cmd_ready = en. On input_ready && cmd_ready: latch x, y, len; go LD (we=0) or ST (we=1).
//   - Store command cycle: FromPE is captured as beat 0 into the store buffer.
// - Issue timing: first mem_req asserts the cycle after accept (registered).
// - Handshake: mem_req, mem_we, mem_x, mem_y and ToMemoryReg stay stable until mem_gnt. en low never drops a pending req.
// - Address advance after each granted beat:
//   - y+1.
//   - y wraps 2**AY_W-1 -> 0 and x+1.
//   - x wraps 2**AX_W-1 -> 0.
// - LD:
//   - credits = FIFO_DEPTH - fifo_count - outstanding.
//   - New read is asserted only if en && credits>0.
//   - gnt: outstanding+1. rvalid: outstanding-1, push FromMemoryReg.
//   - Last beat granted -> IDLE; loads may still be outstanding.
// - ST:
//   - cmd_ready = en && (!stbuf_v || mem_gnt) && beats_captured <= len.
//   - Capture FromPE on input_ready && cmd_ready. mem_req = stbuf_v.
//   - Capture and gnt in the same cycle is allowed (back-to-back beats).
//   - Last beat granted -> IDLE.
// - Load path latency: rvalid at cycle M -> output_ready and ToPE at M+1 (registered FIFO). Pop on output_ready && pe_ready.
// - FIFO: push and pop in the same cycle (including when full) leaves count unchanged. Overflow is impossible by credits.
// - mem_rvalid with outstanding==0 is ignored. No push, no underflow.
// - Reset mid-burst: FSM to IDLE, FIFO and outstanding cleared. Late rvalids are then dropped by the rule above.
// - Memory order is preserved: a store following loads issues only after those reads were granted.
// CONFIGURATION
// - LS_TILE_PERF_EN defined:
//   - Adds output perf_beats [31:0]: count of granted beats (loads+stores), wrapping at 2**32.
//   - Adds output perf_stall [31:0]: cycles with mem_req && !mem_gnt.
//   - Both clear on reset.
// - LS_TILE_PERF_EN undefined: ports and counters absent; other behaviour identical.
// TESTING
// 1 Single load: mem[1][1]=65, ctrl={1,1,len0,we0}, gnt same cycle, rvalid+1 -> one read at (1,1), ToPE=65, output_ready 1 cycle, FSM IDLE.
// 2 Store burst: ctrl={1,2,len3,we1}, FromPE=10,11,12,13 on consecutive cycles, gnt always -> writes (1,2)..(1,5)=10..13, back-to-back, no gaps.
// 3 Wrap: load x=2,y=62,len3 -> addresses (2,62),(2,63),(3,0),(3,1), data in order.
// 4 Backpressure: load len7, pe_ready=0, rvalid 1 cycle after gnt -> exactly 4 reads granted, then mem_req low; pe_ready=1 -> remaining 4 issue, 8 words in order.
// 5 Stall: store len0, mem_gnt low 5 cycles -> mem_req/addr/data stable 6 cycles, cmd_ready low; PERF: perf_stall=5, perf_beats=1.
// 6 Reset mid-burst: load len7, reset high 1 cycle after 2 grants, rvalid pulses follow -> outputs 0, FIFO empty, late rvalids dropped, next command works.

Source files
------------

// File: rtl/ls_tile_burst.sv
// Load/store tile between a PE port and a 2-D (x,y) word memory: single/burst commands,
// in-order req/gnt issue, credit-protected load-return FIFO. Optional perf counters: LS_TILE_PERF_EN.
module ls_tile_burst #(
    parameter int DATA_W     = 32,
    parameter int AX_W       = 6,
    parameter int AY_W       = 6,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [AX_W+AY_W+LEN_W:0] ctrl,
    input  logic                     input_ready,
    input  logic [DATA_W-1:0]        FromPE,
    output logic                     cmd_ready,
    output logic [DATA_W-1:0]        ToPE,
    output logic                     output_ready,
    input  logic                     pe_ready,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [AX_W-1:0]          mem_x,
    output logic [AY_W-1:0]          mem_y,
    output logic [DATA_W-1:0]        ToMemoryReg,
    input  logic                     mem_gnt,
    input  logic [DATA_W-1:0]        FromMemoryReg,
    input  logic                     mem_rvalid
`ifdef LS_TILE_PERF_EN
    ,
    output logic [31:0]              perf_beats,
    output logic [31:0]              perf_stall
`endif
);

    // Handshakes: a transfer happens on a cycle where valid && ready are both high
    // (input_ready/cmd_ready, mem_req/mem_gnt, output_ready/pe_ready); once raised,
    // mem_req and its address/data hold unchanged until the cycle of mem_gnt.

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [LEN_W:0]   CAP_ONE  = 1;
    localparam logic [LEN_W-1:0] BEAT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD   = 2'd1,
        ST   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [AX_W-1:0]   cmd_x;
    logic [AY_W-1:0]   cmd_y;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_we;

    logic [AX_W-1:0]   cur_x;
    logic [AY_W-1:0]   cur_y;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W:0]    cap_cnt;
    logic              stbuf_v;
    logic [DATA_W-1:0] stbuf_data;
    logic              req_pend;
    logic [CNT_W-1:0]  outstanding;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic accept;
    logic st_capture;
    logic gnt_fire;
    logic last_beat;
    logic credit_ok;
    logic rd_issue;
    logic fifo_push;
    logic fifo_pop;

    assign {cmd_x, cmd_y, cmd_len, cmd_we} = ctrl;

    assign accept     = (state == IDLE) && cmd_ready && input_ready;
    assign st_capture = (state == ST) && cmd_ready && input_ready;
    assign gnt_fire   = mem_req && mem_gnt;
    assign last_beat  = (beat_cnt == len_q);
    assign rd_issue   = gnt_fire && !mem_we;

    // Every read in flight owns a FIFO slot, so a return can always be stored.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W + 1)'(FIFO_DEPTH);

    // A return with nothing outstanding is stale (e.g. from before a reset) and is dropped.
    assign fifo_push = mem_rvalid && (outstanding != '0);
    assign fifo_pop  = output_ready && pe_ready;

    assign output_ready = (fifo_count != '0);
    assign ToPE         = fifo_mem[rd_ptr];
    assign mem_x        = cur_x;
    assign mem_y        = cur_y;
    assign ToMemoryReg  = stbuf_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = cmd_we ? ST : LD;
                end
            end
            LD, ST: begin
                if (gnt_fire && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A held read request survives en dropping; only a fresh read waits for en and credit.
    always_comb begin
        cmd_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = en;
            end
            LD: begin
                mem_req = req_pend || (en && credit_ok);
            end
            ST: begin
                mem_we    = 1'b1;
                mem_req   = stbuf_v;
                cmd_ready = en && (!stbuf_v || mem_gnt) && (cap_cnt <= {1'b0, len_q});
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x       <= '0;
            cur_y       <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            cap_cnt     <= '0;
            stbuf_v     <= 1'b0;
            stbuf_data  <= '0;
            req_pend    <= 1'b0;
            outstanding <= '0;
        end else begin
            req_pend <= mem_req && !mem_gnt;

            if (accept) begin
                cur_x    <= cmd_x;
                cur_y    <= cmd_y;
                len_q    <= cmd_len;
                beat_cnt <= '0;
                cap_cnt  <= cmd_we ? CAP_ONE : '0;
            end else if (gnt_fire) begin
                beat_cnt <= beat_cnt + BEAT_ONE;
                cur_y    <= cur_y + AY_W'(1);
                if (cur_y == '1) begin
                    cur_x <= cur_x + AX_W'(1);
                end
            end

            // The store command cycle carries beat 0; later beats may refill on the grant cycle.
            if ((accept && cmd_we) || st_capture) begin
                stbuf_data <= FromPE;
                stbuf_v    <= 1'b1;
            end else if (gnt_fire && mem_we) begin
                stbuf_v <= 1'b0;
            end

            if (st_capture) begin
                cap_cnt <= cap_cnt + CAP_ONE;
            end

            case ({rd_issue, fifo_push})
                2'b10:   outstanding <= outstanding + CNT_ONE;
                2'b01:   outstanding <= outstanding - CNT_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= FromMemoryReg;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef LS_TILE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_beats <= '0;
            perf_stall <= '0;
        end else begin
            if (gnt_fire) begin
                perf_beats <= perf_beats + 32'd1;
            end
            if (mem_req && !mem_gnt) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ls_tile_burst.sv
// Self-checking bench for ls_tile_burst: scripted PE side, responding memory model,
// request/return scoreboards. Perf checks are compiled in with LS_TILE_PERF_EN.
module tb_ls_tile_burst;

    localparam int DATA_W     = 32;
    localparam int AX_W       = 6;
    localparam int AY_W       = 6;
    localparam int LEN_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int REQ_W      = 1 + AX_W + AY_W + DATA_W;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     en = 1'b0;
    logic [AX_W+AY_W+LEN_W:0] ctrl = '0;
    logic                     input_ready = 1'b0;
    logic [DATA_W-1:0]        FromPE = '0;
    logic                     cmd_ready;
    logic [DATA_W-1:0]        ToPE;
    logic                     output_ready;
    logic                     pe_ready = 1'b0;
    logic                     mem_req;
    logic                     mem_we;
    logic [AX_W-1:0]          mem_x;
    logic [AY_W-1:0]          mem_y;
    logic [DATA_W-1:0]        ToMemoryReg;
    logic                     mem_gnt = 1'b1;
    logic [DATA_W-1:0]        FromMemoryReg = '0;
    logic                     mem_rvalid = 1'b0;
`ifdef LS_TILE_PERF_EN
    logic [31:0]              perf_beats;
    logic [31:0]              perf_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gnt_cnt = 0;
    int rd_lat = 1;

    logic [DATA_W-1:0] exp_q[$];
    logic [REQ_W-1:0]  exp_req_q[$];
    logic [DATA_W-1:0] rd_data_q[$];
    int                rd_due_q[$];
    int                gnt_stamp_q[$];
    logic [REQ_W-1:0]  mon_got;
    logic [REQ_W-1:0]  mon_exp;
    logic [DATA_W-1:0] mon_word;

    ls_tile_burst #(
        .DATA_W(DATA_W), .AX_W(AX_W), .AY_W(AY_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .ctrl(ctrl),
        .input_ready(input_ready),
        .FromPE(FromPE),
        .cmd_ready(cmd_ready),
        .ToPE(ToPE),
        .output_ready(output_ready),
        .pe_ready(pe_ready),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_x(mem_x),
        .mem_y(mem_y),
        .ToMemoryReg(ToMemoryReg),
        .mem_gnt(mem_gnt),
        .FromMemoryReg(FromMemoryReg),
        .mem_rvalid(mem_rvalid)
`ifdef LS_TILE_PERF_EN
        ,
        .perf_beats(perf_beats),
        .perf_stall(perf_stall)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Memory contents seen by reads: address pattern plus the single-load word
    function automatic logic [DATA_W-1:0] mem_word(input int x, input int y);
        if (x == 1 && y == 1) return 32'd65;
        return 32'h1000_0000 + DATA_W'(x * 256 + y);
    endfunction

    // Memory responder: read data returns rd_lat cycles after its grant
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rd_due_q.size() > 0 && rd_due_q[0] <= cyc) begin
            mem_rvalid    = 1'b1;
            FromMemoryReg = rd_data_q.pop_front();
            void'(rd_due_q.pop_front());
        end else begin
            mem_rvalid    = 1'b0;
            FromMemoryReg = '0;
        end
    end

    // Scoreboard: granted requests and PE-side returns are checked against the queues
    always @(negedge clk) begin
        if (!reset && mem_req && mem_gnt) begin
            gnt_cnt++;
            gnt_stamp_q.push_back(cyc);
            mon_got = {mem_we, mem_x, mem_y, (mem_we ? ToMemoryReg : {DATA_W{1'b0}})};
            if (!mem_we) begin
                rd_data_q.push_back(mem_word(int'(mem_x), int'(mem_y)));
                rd_due_q.push_back(cyc + rd_lat);
            end
            checks++;
            if (exp_req_q.size() == 0) begin
                errors++;
                $display("FAIL mem_request: got unexpected request %h, required none", mon_got);
            end else begin
                mon_exp = exp_req_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL mem_request: got %h required %h", mon_got, mon_exp);
                end
            end
        end
        if (!reset && output_ready && pe_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL to_pe: got unexpected word %h, required none", ToPE);
            end else begin
                mon_word = exp_q.pop_front();
                if (ToPE !== mon_word) begin
                    errors++;
                    $display("FAIL to_pe: got %h required %h", ToPE, mon_word);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load(input int x, input int y, input int len);
        int cx = x;
        int cy = y;
        for (int b = 0; b <= len; b++) begin
            exp_req_q.push_back({1'b0, AX_W'(cx), AY_W'(cy), {DATA_W{1'b0}}});
            exp_q.push_back(mem_word(cx, cy));
            cy++;
            if (cy == 2**AY_W) begin
                cy = 0;
                cx = (cx + 1) % (2**AX_W);
            end
        end
    endtask

    task automatic push_store(input int x, input int y, input int len, input logic [DATA_W-1:0] base);
        int cx = x;
        int cy = y;
        for (int b = 0; b <= len; b++) begin
            exp_req_q.push_back({1'b1, AX_W'(cx), AY_W'(cy), base + DATA_W'(b)});
            cy++;
            if (cy == 2**AY_W) begin
                cy = 0;
                cx = (cx + 1) % (2**AX_W);
            end
        end
    endtask

    // Presents a command (or store beat when cmd=0) until cmd_ready is seen, then releases input_ready
    task automatic send_item(input logic is_cmd, input int x, input int y, input int len,
                             input logic we, input logic [DATA_W-1:0] d);
        int ok = 0;
        if (is_cmd) ctrl = {AX_W'(x), AY_W'(y), LEN_W'(len), we};
        FromPE      = d;
        input_ready = 1'b1;
        for (int i = 0; i < 50 && ok == 0; i++) begin
            @(negedge clk);
            if (cmd_ready) ok = 1;
        end
        @(posedge clk);
        #1;
        input_ready = 1'b0;
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready stayed 0 for 50 cycles, required 1");
        end
    endtask

    task automatic wait_drain(input int budget, output int ok);
        ok = 0;
        for (int i = 0; i < budget && ok == 0; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_req_q.size() == 0 && rd_due_q.size() == 0) ok = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({cmd_ready, mem_req, mem_we, output_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {cmd_ready, mem_req, mem_we, output_ready});
        end
        checks++;
        if ({mem_x, mem_y} !== '0) begin
            errors++;
            $display("FAIL reset_addr: got x=%0d y=%0d required 0,0", mem_x, mem_y);
        end
        checks++;
        if (ToPE !== '0 || ToMemoryReg !== '0) begin
            errors++;
            $display("FAIL reset_data: got ToPE=%h ToMemoryReg=%h required 0", ToPE, ToMemoryReg);
        end
`ifdef LS_TILE_PERF_EN
        checks++;
        if (perf_beats !== 32'd0 || perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got beats=%0d stall=%0d required 0,0", perf_beats, perf_stall);
        end
`endif
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_en_low: got cmd_ready=%b required 0", cmd_ready);
        end
        tick();
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_en_high: got cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_single_load();
        int cnt = 0;
        tick();
        mem_gnt  = 1'b1;
        pe_ready = 1'b1;
        rd_lat   = 1;
        push_load(1, 1, 0);
        send_item(1'b1, 1, 1, 0, 1'b0, '0);
        repeat (8) begin
            @(negedge clk);
            if (output_ready) cnt++;
        end
        checks++;
        if (cnt != 1) begin
            errors++;
            $display("FAIL single_load_ready: got %0d ready cycles required 1", cnt);
        end
        checks++;
        if (exp_q.size() != 0 || exp_req_q.size() != 0) begin
            errors++;
            $display("FAIL single_load_done: got %0d words %0d reqs left required 0,0", exp_q.size(), exp_req_q.size());
        end
        checks++;
        if (cmd_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL single_load_idle: got cmd_ready=%b mem_req=%b required 1,0", cmd_ready, mem_req);
        end
    endtask

    task automatic test_store_burst();
        int gap;
        tick();
        push_store(1, 2, 3, 32'd10);
        gnt_stamp_q.delete();
        send_item(1'b1, 1, 2, 3, 1'b1, 32'd10);
        for (int b = 1; b <= 3; b++) send_item(1'b0, 0, 0, 0, 1'b0, 32'd10 + DATA_W'(b));
        repeat (4) @(negedge clk);
        gap = (gnt_stamp_q.size() == 4) ? (gnt_stamp_q[3] - gnt_stamp_q[0]) : -1;
        checks++;
        if (gap != 3) begin
            errors++;
            $display("FAIL store_back_to_back: got %0d grants spanning %0d cycles required 4 in 3", gnt_stamp_q.size(), gap);
        end
        checks++;
        if (exp_req_q.size() != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL store_done: got %0d reqs left cmd_ready=%b required 0,1", exp_req_q.size(), cmd_ready);
        end
    endtask

    task automatic test_wrap();
        int ok;
        tick();
        push_load(2, 62, 3);
        send_item(1'b1, 2, 62, 3, 1'b0, '0);
        push_load(63, 63, 1);
        send_item(1'b1, 63, 63, 1, 1'b0, '0);
        wait_drain(200, ok);
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL wrap_drain: got %0d words %0d reqs left required 0,0", exp_q.size(), exp_req_q.size());
        end
    endtask

    task automatic test_backpressure();
        int base;
        int ok;
        tick();
        pe_ready = 1'b0;
        base = gnt_cnt;
        push_load(5, 0, 7);
        send_item(1'b1, 5, 0, 7, 1'b0, '0);
        repeat (12) @(negedge clk);
        checks++;
        if (gnt_cnt - base != 4 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_credit_stop: got %0d grants mem_req=%b required 4,0", gnt_cnt - base, mem_req);
        end
        checks++;
        if (output_ready !== 1'b1 || ToPE !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_head: got ready=%b ToPE=%h required 1,%h", output_ready, ToPE, exp_q[0]);
        end
        tick();
        pe_ready = 1'b1;
        wait_drain(200, ok);
        checks++;
        if (ok == 0 || gnt_cnt - base != 8) begin
            errors++;
            $display("FAIL bp_resume: got %0d grants %0d words left required 8,0", gnt_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] d = 32'hABCD_0001;
        tick();
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        mem_gnt = 1'b0;
        push_store(7, 9, 0, d);
        send_item(1'b1, 7, 9, 0, 1'b1, d);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                tick();
                mem_gnt = 1'b1;
            end
            @(negedge clk);
            checks++;
            if ({mem_req, mem_we, cmd_ready, mem_x, mem_y, ToMemoryReg} !== {3'b110, 6'd7, 6'd9, d}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got req=%b we=%b rdy=%b x=%0d y=%0d d=%h required 1,1,0,7,9,%h",
                         i, mem_req, mem_we, cmd_ready, mem_x, mem_y, ToMemoryReg, d);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || cmd_ready !== 1'b1 || exp_req_q.size() != 0) begin
            errors++;
            $display("FAIL stall_done: got mem_req=%b cmd_ready=%b reqs=%0d required 0,1,0", mem_req, cmd_ready, exp_req_q.size());
        end
`ifdef LS_TILE_PERF_EN
        checks++;
        if (perf_stall !== 32'd5 || perf_beats !== 32'd1) begin
            errors++;
            $display("FAIL stall_perf: got stall=%0d beats=%0d required 5,1", perf_stall, perf_beats);
        end
`endif
    endtask

    task automatic test_reset_mid_burst();
        int base;
        int ok = 0;
        int cnt = 0;
        tick();
        pe_ready = 1'b0;
        rd_lat   = 3;
        base = gnt_cnt;
        push_load(10, 0, 7);
        send_item(1'b1, 10, 0, 7, 1'b0, '0);
        for (int i = 0; i < 40 && ok == 0; i++) begin
            @(negedge clk);
            if (gnt_cnt - base >= 2) ok = 1;
        end
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL mid_burst_grants: got %0d grants required 2", gnt_cnt - base);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_req_q.delete();
        @(negedge clk);
        checks++;
        if ({output_ready, mem_req, cmd_ready} !== 3'b001 || ToPE !== '0 || {mem_x, mem_y} !== '0) begin
            errors++;
            $display("FAIL mid_burst_reset: got ready=%b req=%b cmd_ready=%b ToPE=%h x=%0d y=%0d required 0,0,1,0,0,0",
                     output_ready, mem_req, cmd_ready, ToPE, mem_x, mem_y);
        end
        repeat (6) begin
            @(negedge clk);
            if (output_ready) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++;
            $display("FAIL late_rvalid_drop: got %0d ready cycles required 0", cnt);
        end
        tick();
        rd_lat   = 1;
        pe_ready = 1'b1;
        push_load(4, 4, 1);
        send_item(1'b1, 4, 4, 1, 1'b0, '0);
        wait_drain(100, ok);
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL after_reset_load: got %0d words %0d reqs left required 0,0", exp_q.size(), exp_req_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store_burst();
        test_wrap();
        test_backpressure();
        test_stall();
        test_reset_mid_burst();
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
